// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: next-PC source encoding and
// the alignment mask derived from the sequential increment.
package pc_pkg;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_JMP,
        SRC_RET,
        SRC_PEND,
        SRC_TRAP,
        SRC_HOLD
    } pc_src_e;

    // Low address bits that must be zero for a target to be INC-aligned.
    function automatic int unsigned align_mask(input int unsigned inc);
        return inc - 1;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack for pc_unit (built only with PC_RAS_EN).
// Push on a full stack overwrites the oldest entry; top of an empty stack is RESET_VEC.
module pc_ras #(
    parameter int                 WIDTH     = 32,
    parameter int                 DEPTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VEC = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW:0]      count;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic [PW-1:0]    wr_idx;

    assign empty  = (count == '0);
    assign full   = (count == (PW+1)'(DEPTH));
    assign do_pop = pop && !empty;
    // Pop-then-push lands the new address on the slot just popped.
    assign wr_idx = do_pop ? ptr - 1'b1 : ptr;
    assign top    = empty ? RESET_VEC : mem[ptr - 1'b1];

    always_ff @(negedge clk) begin
        if (clr) begin
            ptr   <= '0;
            count <= '0;
        end else begin
            unique case ({push, do_pop})
                2'b10: begin
                    ptr   <= ptr + 1'b1;
                    count <= full ? count : count + 1'b1;
                end
                2'b01: begin
                    ptr   <= ptr - 1'b1;
                    count <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the entries need no reset; count gates every read, so stale data is never visible.
    always_ff @(negedge clk) begin
        if (push && !clr)
            mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: increment, branch/jump/trap redirect, stall hold with a
// one-entry pending-redirect buffer. Optional return-address stack under PC_RAS_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h0000_0180,
    parameter int               INC       = 4,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Stall,
    input  logic             BrTaken,
    input  logic [WIDTH-1:0] BrTarget,
    input  logic             JmpTaken,
    input  logic [WIDTH-1:0] JmpTarget,
    input  logic             Trap,
    input  logic             Call,
    input  logic             Ret,
    output logic [WIDTH-1:0] PCout,
    output logic [WIDTH-1:0] PCplus,
    output logic             Redirected,
    output logic             MisalignErr,
    output logic             PendValid
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(align_mask(INC));

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             redir_q, redir_d;
    logic             mis_q, mis_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;

    logic             ret_req;
    logic [WIDTH-1:0] ras_top;
    logic             live_valid;
    logic [WIDTH-1:0] live_target;
    pc_src_e          live_src;
    pc_src_e          src;
    logic [WIDTH-1:0] target;
    logic             misaligned;

`ifdef PC_RAS_EN
    assign ret_req = Ret;

    pc_ras #(
        .WIDTH     (WIDTH),
        .DEPTH     (RAS_DEPTH),
        .RESET_VEC (RESET_VEC)
    ) u_ras (
        .clk       (Clk),
        .clr       (Clr),
        .push      (Call && JmpTaken && !Stall && !Trap),
        .pop       (Ret && !Trap),
        .push_data (PCplus),
        .top       (ras_top)
    );
`else
    logic unused_ras;
    assign unused_ras = ^{Call, Ret, RAS_DEPTH[0]};
    assign ret_req    = 1'b0;
    assign ras_top    = RESET_VEC;
`endif

    assign PCplus = pc_q + WIDTH'(INC);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        live_valid  = JmpTaken || ret_req || BrTaken;
        live_src    = SRC_BR;
        live_target = BrTarget;
        if (JmpTaken) begin
            live_src    = SRC_JMP;
            live_target = JmpTarget;
        end else if (ret_req) begin
            live_src    = SRC_RET;
            live_target = ras_top;
        end

        if (Trap)                      src = SRC_TRAP;
        else if (!Stall && live_valid) src = live_src;
        else if (!Stall && pend_valid_q) src = SRC_PEND;
        else if (Stall)                src = SRC_HOLD;
        else                           src = SRC_SEQ;

        target = (src == SRC_PEND) ? pend_target_q : live_target;
        misaligned = (target & ALIGN_MASK) != '0;

        pc_d          = PCplus;
        redir_d       = 1'b0;
        mis_d         = 1'b0;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;

        unique case (src)
            SRC_TRAP: begin
                pc_d          = TRAP_VEC;
                redir_d       = 1'b1;
                pend_valid_d  = 1'b0;
                pend_target_d = '0;
            end
            SRC_BR, SRC_JMP, SRC_RET, SRC_PEND: begin
                // Alignment is judged only now, when the target is actually applied.
                pc_d          = misaligned ? TRAP_VEC : target;
                mis_d         = misaligned;
                redir_d       = 1'b1;
                pend_valid_d  = 1'b0;
                pend_target_d = '0;
            end
            SRC_HOLD: begin
                pc_d = pc_q;
                if (live_valid) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = live_target;
                end
            end
            default: pc_d = PCplus;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(negedge Clk) begin
        if (Clr) begin
            pc_q          <= RESET_VEC;
            redir_q       <= 1'b0;
            mis_q         <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            redir_q       <= redir_d;
            mis_q         <= mis_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign PCout       = pc_q;
    assign Redirected  = redir_q;
    assign MisalignErr = mis_q;
    assign PendValid   = pend_valid_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: cycle-by-cycle vector table plus directed
// sequences for the stack-disabled Call/Ret case or, with PC_RAS_EN, the stack.
module tb_pc_unit;

    logic        Clk = 1'b0;
    logic        Clr, Stall, BrTaken, JmpTaken, Trap, Call, Ret;
    logic [31:0] BrTarget, JmpTarget;
    logic [31:0] PCout, PCplus;
    logic        Redirected, MisalignErr, PendValid;

    int checks   = 0;
    int failures = 0;

    pc_unit dut (
        .Clk         (Clk),
        .Clr         (Clr),
        .Stall       (Stall),
        .BrTaken     (BrTaken),
        .BrTarget    (BrTarget),
        .JmpTaken    (JmpTaken),
        .JmpTarget   (JmpTarget),
        .Trap        (Trap),
        .Call        (Call),
        .Ret         (Ret),
        .PCout       (PCout),
        .PCplus      (PCplus),
        .Redirected  (Redirected),
        .MisalignErr (MisalignErr),
        .PendValid   (PendValid)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        clr;
        logic        stall;
        logic        br;
        logic [31:0] brt;
        logic        jmp;
        logic [31:0] jmpt;
        logic        trap;
        logic [31:0] pc;
        logic        redir;
        logic        mis;
        logic        pend;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic clr, input logic stall, input logic br, input logic [31:0] brt,
                       input logic jmp, input logic [31:0] jmpt, input logic trap,
                       input logic [31:0] pc, input logic redir, input logic mis, input logic pend);
        vec_t v;
        v.clr = clr; v.stall = stall; v.br = br; v.brt = brt; v.jmp = jmp; v.jmpt = jmpt;
        v.trap = trap; v.pc = pc; v.redir = redir; v.mis = mis; v.pend = pend;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic redir,
                               input logic mis, input logic pend);
        check({tag, " PCout"}, PCout, pc);
        check({tag, " PCplus"}, PCplus, pc + 32'd4);
        check({tag, " Redirected"}, {31'd0, Redirected}, {31'd0, redir});
        check({tag, " MisalignErr"}, {31'd0, MisalignErr}, {31'd0, mis});
        check({tag, " PendValid"}, {31'd0, PendValid}, {31'd0, pend});
    endtask

    task automatic idle_inputs();
        Clr = 0; Stall = 0; BrTaken = 0; BrTarget = '0; JmpTaken = 0; JmpTarget = '0;
        Trap = 0; Call = 0; Ret = 0;
    endtask

    // Inputs change just after a falling edge; outputs are sampled 1ns after the next one.
    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    initial begin
        idle_inputs();

        //   clr stall br brt           jmp jmpt          trap  pc            r  m  p
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0000, 0, 0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0000, 0, 0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0004, 0, 0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0008, 0, 0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_000C, 0, 0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0010, 0, 0, 0);
        add(0, 0, 1, 32'h100,       0, 32'h0,         0, 32'h0000_0100, 1, 0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0104, 0, 0, 0);
        add(0, 1, 1, 32'h200,       0, 32'h0,         0, 32'h0000_0104, 0, 0, 1);
        add(0, 1, 0, 32'h0,         1, 32'h300,       0, 32'h0000_0104, 0, 0, 1);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0104, 0, 0, 1);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0300, 1, 0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0304, 0, 0, 0);
        add(0, 0, 0, 32'h0,         1, 32'h102,       0, 32'h0000_0180, 1, 1, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0184, 0, 0, 0);
        add(0, 1, 1, 32'h400,       0, 32'h0,         0, 32'h0000_0184, 0, 0, 1);
        add(0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0180, 1, 0, 0);
        add(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0180, 0, 0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0184, 0, 0, 0);
        add(0, 1, 1, 32'h200,       1, 32'h500,       0, 32'h0000_0184, 0, 0, 1);
        add(0, 0, 1, 32'h600,       0, 32'h0,         0, 32'h0000_0600, 1, 0, 0);
        add(0, 1, 1, 32'h702,       0, 32'h0,         0, 32'h0000_0600, 0, 0, 1);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0180, 1, 1, 0);
        add(0, 0, 1, 32'h900,       1, 32'h800,       0, 32'h0000_0800, 1, 0, 0);
        add(0, 0, 0, 32'h0,         1, 32'hA00,       1, 32'h0000_0180, 1, 0, 0);
        add(0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0000, 0, 0, 0);
        add(0, 1, 1, 32'h40,        0, 32'h0,         0, 32'h0000_0000, 0, 0, 1);
        add(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0000, 0, 0, 0);
        add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0004, 0, 0, 0);

        foreach (vq[i]) begin
            Clr = vq[i].clr; Stall = vq[i].stall;
            BrTaken = vq[i].br; BrTarget = vq[i].brt;
            JmpTaken = vq[i].jmp; JmpTarget = vq[i].jmpt;
            Trap = vq[i].trap;
            tick();
            check_state($sformatf("vec%0d", i), vq[i].pc, vq[i].redir, vq[i].mis, vq[i].pend);
        end
        idle_inputs();

`ifdef PC_RAS_EN
        // Five calls through a four-deep stack, then five returns (last one underflows).
        JmpTaken = 1; JmpTarget = 32'h10;
        tick();
        check_state("ras_start", 32'h10, 1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            Call = 1; JmpTaken = 1; JmpTarget = 32'h10 * (k + 1);
            tick();
            check_state($sformatf("call%0d", k), 32'h10 * (k + 1), 1, 0, 0);
        end
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            logic [31:0] exp_ret;
            exp_ret = (k < 4) ? 32'h54 - 32'h10 * k : 32'h0;
            Ret = 1;
            tick();
            check_state($sformatf("ret%0d", k), exp_ret, 1, 0, 0);
        end
        idle_inputs();
`else
        // Without the stack, Call and Ret must not disturb sequential fetch.
        Call = 1; Ret = 1;
        tick();
        check_state("ret_ignored", 32'h8, 0, 0, 0);
        Stall = 1;
        tick();
        check_state("ret_ignored_stall", 32'h8, 0, 0, 0);
        idle_inputs();
        tick();
        check_state("ret_ignored_release", 32'hC, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
